regread_arbiter: RTL
====================

# regread_arbiter

Round-robin arbiter and sequencer for the shared register-file read port: the 32-entry array whose every bit slice is a 32:1 select mux driven by one 5-bit select. Four requesters (fetch/decode read A, read B, debug, forwarding check) share this single port. The block picks a winner, drives the mux select, waits one cycle for the mux tree to settle, captures the data and returns it tagged with the requester ID.

## Interface
- `WIDTH`, 64: register/data width; the number of mux32_1 slices on the read port.
- `NREQ`, 4: number of requesters, fixed at 4. The ID is 2 bits.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input [NREQ-1:0]: per-requester request. Must be held until the matching `gnt` bit pulses.
- `addr` input [NREQ*5-1:0]: per-requester register number. Requester i uses bits [5i+4:5i] and holds them while `req[i]` is high.
- `gnt` output [NREQ-1:0]: one-hot grant, one-cycle pulse.
- `rd_sel` output [4:0]: registered select to the read-port mux array.
- `rd_data` input [WIDTH-1:0]: mux array output. Valid one full cycle after `rd_sel` changes.
- `resp_valid` output 1: one-cycle pulse, response available.
- `resp_id` output [1:0]: requester the response belongs to.
- `resp_data` output [WIDTH-1:0]: captured read data.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SEL, CAPT.
  - IDLE: if `|req`, arbitrate and go to SEL. Otherwise stay.
  - SEL: the mux settles. Always go to CAPT.
  - CAPT: latch `rd_data`. If `|req`, arbitrate and go to SEL (back-to-back). Otherwise go to IDLE.
- Arbitration is round-robin. `last` holds the last granted ID. Search order is `last+1`, `last+2`, … mod 4, and the first set `req` bit wins.
- On the arbitration edge: `rd_sel` ← winner's `addr`, `gnt[winner]` ← 1 for one cycle, `owner` ← winner, `last` ← winner.
- On the CAPT edge: `resp_data` ← `rd_data`, `resp_id` ← `owner`, `resp_valid` ← 1 for one cycle.
- A requester that drops `req` before `gnt` is simply not served. No state is kept for it.
- A `req` bit that is still high in the cycle its `gnt` pulses counts as a new request at the next arbitration point.
- `rd_sel` holds its value between grants. It is never driven to X.

## Timing
- Reset values: state = IDLE, `gnt` = 0, `rd_sel` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0, `last` = 3 (so requester 0 has highest priority after reset), `busy` = 0.
- All outputs are registered.
- Latency from `req` sampled in IDLE at edge E:
  - `gnt` and `rd_sel` change at E.
  - CAPT is entered at E+1.
  - `resp_valid` is high after edge E+2, i.e. 2 cycles from grant to response.
- Sustained throughput is one read per 2 cycles. Back-to-back grants are spaced exactly 2 cycles apart.
- `resp_valid` of read n and `gnt` of read n+1 assert on the same edge.
- Reset asserted mid-transaction (SEL or CAPT) aborts it. No `resp_valid` is produced and all outputs return to reset values asynchronously.
- The first arbitration after reset release happens at the first rising edge with `req` ≠ 0.

## Configuration
- Macro: `REGREAD_ZERO_REG_EN`.
- Defined:
  - A grant for address 31 (XZR) still drives `rd_sel` = 31 and takes the same 2-cycle timing.
  - `resp_data` is forced to all zeros instead of `rd_data`.
- Undefined: address 31 returns `rd_data` like any other register.

## Test plan
- Reset, then `req` = 4'b0001, `addr0` = 5, `rd_data` = reg5 pattern `64'hCA88_F0C3_0000_0005` → `gnt` = 0001 at edge 1, `rd_sel` = 5, `resp_valid` at edge 3 with `resp_id` = 0 and the matching data.
- All four `req` held high with addresses 1,2,3,4 → grants in order 0,1,2,3,0 at 2-cycle spacing; each `resp_id`/`resp_data` pair matches its address.
- `last` = 1 and `req` = 4'b0101 → requester 2 is granted before 0.
- `reset_n` pulled low during SEL → `resp_valid` never pulses. All outputs are 0 immediately, before the next clock edge.
- `addr` = 31 with `rd_data` = `64'hFFFF…` → `resp_data` = 0 when `REGREAD_ZERO_REG_EN` is defined, all-ones when undefined.
- `req[2]` dropped one cycle before its turn → it is skipped and no response carries `resp_id` = 2.

Source files
------------

// File: rtl/regread_arbiter.sv
// Round-robin arbiter/sequencer for the shared 32-entry register-file read port.
// Optional REGREAD_ZERO_REG_EN: reads of register 31 (XZR) return all zeros.
module regread_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*5-1:0]    addr,
  output logic [NREQ-1:0]      gnt,
  output logic [4:0]           rd_sel,
  input  logic [WIDTH-1:0]     rd_data,
  output logic                 resp_valid,
  output logic [1:0]           resp_id,
  output logic [WIDTH-1:0]     resp_data,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StSel, StCapt} state_e;

  state_e           state_q;
  logic [1:0]       last_q;
  logic [1:0]       owner_q;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic [4:0]       win_addr;
  logic             any_req;
  logic             arb;
  logic [WIDTH-1:0] capt_data;

  assign any_req = |req;
  assign arb     = any_req && ((state_q == StIdle) || (state_q == StCapt));

  // Scan from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    winner = last_q;
    cand   = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req[cand]) winner = cand;
    end
  end

  assign win_addr = addr[5*int'(winner) +: 5];

`ifdef REGREAD_ZERO_REG_EN
  assign capt_data = (rd_sel == 5'd31) ? '0 : rd_data;
`else
  assign capt_data = rd_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      last_q     <= 2'd3;
      owner_q    <= 2'd0;
      gnt        <= '0;
      rd_sel     <= 5'd0;
      resp_valid <= 1'b0;
      resp_id    <= 2'd0;
      resp_data  <= '0;
      busy       <= 1'b0;
    end else begin
      gnt        <= '0;
      resp_valid <= 1'b0;
      if (arb) begin
        rd_sel  <= win_addr;
        gnt     <= NREQ'(1) << winner;
        owner_q <= winner;
        last_q  <= winner;
      end
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StSel;
            busy    <= 1'b1;
          end
        end
        StSel: begin
          state_q <= StCapt;
          busy    <= 1'b1;
        end
        StCapt: begin
          resp_data  <= capt_data;
          resp_id    <= owner_q;
          resp_valid <= 1'b1;
          if (any_req) begin
            state_q <= StSel;
            busy    <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
